// File: rtl/pulse_stretch_if.sv
// Event-side signals of pulse_stretch: strobe/clear in, stretched level and status out.
// dbg_state exposes the FSM encoding (IDLE=0, HIGH=1, GAP=2) for checkers.
interface pulse_stretch_if;
   logic       pulse_in;
   logic       ovf_clr;
   logic       level_out;
   logic       busy;
   logic [3:0] pend_cnt;
   logic       overflow;
   logic [1:0] dbg_state;

   modport master (
      output pulse_in, ovf_clr,
      input  level_out, busy, pend_cnt, overflow, dbg_state
   );

   modport slave (
      input  pulse_in, ovf_clr,
      output level_out, busy, pend_cnt, overflow, dbg_state
   );
endinterface

// File: rtl/pulse_stretch.sv
// Pulse stretcher: each strobe becomes HIGH_CYC high cycles followed by GAP_CYC low cycles.
// Define PULSE_STRETCH_QUEUE_EN to queue strobes arriving while busy (else they are dropped).
module pulse_stretch #(
   parameter int unsigned HIGH_CYC = 8,
   parameter int unsigned GAP_CYC  = 2,
   parameter int unsigned QDEPTH   = 3
) (
   input  logic           clock,
   input  logic           reset,
   pulse_stretch_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [7:0] HIGH_LD = 8'(HIGH_CYC - 1);
   localparam logic [7:0] GAP_LD  = 8'(GAP_CYC - 1);
`ifdef PULSE_STRETCH_QUEUE_EN
   localparam logic [3:0] PEND_MAX = 4'(QDEPTH);
`else
   // Zero capacity: every strobe while busy is a drop, pend_cnt stays 0.
   localparam logic [3:0] PEND_MAX = 4'd0;
`endif

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [3:0] r_pend;
   logic       r_ovf;
   logic       r_level;
   logic       r_busy;

   state_t     w_state_nxt;
   logic [7:0] w_cnt_nxt;
   logic [3:0] w_pend_nxt;
   logic       w_queue_req;
   logic       w_drop;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_queue_req = 1'b0;
      w_drop      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.pulse_in) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = HIGH_LD;
            end
         end
         S_HIGH: begin
            w_queue_req = bus.pulse_in;
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = GAP_LD;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_GAP: begin
            if (r_cnt != 8'd0) begin
               w_queue_req = bus.pulse_in;
               w_cnt_nxt   = r_cnt - 8'd1;
            end else if (r_pend != 4'd0) begin
               // A coincident strobe replaces the consumed entry, net count unchanged.
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = HIGH_LD;
               if (!bus.pulse_in) begin
                  w_pend_nxt = r_pend - 4'd1;
               end
            end else if (bus.pulse_in) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = HIGH_LD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase

      if (w_queue_req) begin
         if (r_pend < PEND_MAX) begin
            w_pend_nxt = r_pend + 4'd1;
         end else begin
            w_drop = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_pend  <= 4'd0;
         r_ovf   <= 1'b0;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         // Set beats clear when a drop and ovf_clr coincide.
         r_ovf   <= (r_ovf & ~bus.ovf_clr) | w_drop;
         r_level <= (w_state_nxt == S_HIGH);
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   assign bus.level_out = r_level;
   assign bus.busy      = r_busy;
   assign bus.pend_cnt  = r_pend;
   assign bus.overflow  = r_ovf;
   assign bus.dbg_state = r_state;

endmodule
